mips_mem_bridge: RTL and testbench

Unified-memory bridge for the MIPS core. It places instruction fetch and load/store traffic on one shared, variable-latency memory port with a req/ack handshake. It stalls the core until both accesses of the current instruction have completed. It sits between the core's instruction/data ports and a single external memory, and replaces the split zero-latency instruction/data memory arrangement.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_bridge_watchdog.sv | 40 ++++
 rtl/mips_mem_bridge.sv | 119 +++++++++++
 tb/tb_mips_mem_bridge.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS core and its unified-memory bridge.
package mips_pkg;

  typedef enum logic [2:0] {
    BR_IDLE,
    BR_FETCH,
    BR_DATA,
    BR_EXEC,
    BR_ERR
  } bridge_state_t;

  localparam int BRIDGE_TIMEOUT_DEF = 64;

  // Counter width for a watchdog limit; never narrower than one bit.
  function automatic int wd_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/mips_bridge_watchdog.sv
// Counts unacknowledged request cycles; expired pulses in the cycle that would
// be the TIMEOUT-th one, so the owner can leave on that same edge.
module mips_bridge_watchdog
  import mips_pkg::*;
#(
  parameter int TIMEOUT = BRIDGE_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int W = wd_width(TIMEOUT);
      localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

      logic [W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear)         cnt_d = '0;
        else if (count_en) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      // count_en already excludes an acking cycle, so a last-cycle ack wins.
      assign expired = count_en && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/mips_mem_bridge.sv
// Serialises instruction fetch and load/store onto one req/ack memory port and
// stalls the core until both accesses of the current instruction are done.
module mips_mem_bridge
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = BRIDGE_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] core_pc,
  output logic [DATA_WIDTH-1:0] core_instr,
  input  logic                  core_memread,
  input  logic                  core_memwrite,
  input  logic [ADDR_WIDTH-1:0] core_memaddr,
  input  logic [DATA_WIDTH-1:0] core_writedata,
  output logic [DATA_WIDTH-1:0] core_readdata,
  output logic                  core_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  bus_err
);

  bridge_state_t         state_q, state_d;
  logic                  decide_q, decide_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_v, wd_expired, wd_clear;

  // decide_q marks the cycle after fetch ack, when the core decodes instr_q.
  assign mem_req = ((state_q == BR_FETCH) && !decide_q) || (state_q == BR_DATA);
  assign ack_v   = mem_req && mem_ack;

  always_comb begin
    state_d  = state_q;
    decide_d = decide_q;
    instr_d  = instr_q;
    rdata_d  = rdata_q;
    case (state_q)
      BR_IDLE: begin
        state_d  = BR_FETCH;
        decide_d = 1'b0;
      end
      BR_FETCH: begin
        if (decide_q) begin
          decide_d = 1'b0;
          state_d  = (core_memread || core_memwrite) ? BR_DATA : BR_EXEC;
        end else if (ack_v) begin
          instr_d  = mem_rdata;
          decide_d = 1'b1;
        end else if (wd_expired) begin
          state_d = BR_ERR;
        end
      end
      BR_DATA: begin
        if (ack_v) begin
          if (core_memread && !core_memwrite) rdata_d = mem_rdata;
          state_d = BR_EXEC;
        end else if (wd_expired) begin
          state_d = BR_ERR;
        end
      end
      BR_EXEC: state_d = BR_FETCH;
      BR_ERR:  state_d = BR_ERR;
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BR_IDLE;
      decide_q <= 1'b0;
      instr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      decide_q <= decide_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign wd_clear = ack_v || (state_d != state_q);

  mips_bridge_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .count_en (mem_req && !mem_ack),
    .expired  (wd_expired)
  );

  // Store wins when both memread and memwrite are asserted.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      BR_FETCH: mem_addr = core_pc;
      BR_DATA: begin
        mem_addr  = core_memaddr;
        mem_we    = core_memwrite;
        mem_wdata = core_writedata;
      end
      default: ;
    endcase
  end

  assign core_stall    = (state_q != BR_EXEC);
  assign bus_err       = (state_q == BR_ERR);
  assign core_instr    = instr_q;
  assign core_readdata = rdata_q;

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Directed bench: a variable-wait memory, an expected-access queue checked every
// cycle, and per-instruction cycle-cost and latched-data checks.
module tb_mips_mem_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  localparam logic [31:0] ADD = 32'h012A4020;
  localparam logic [31:0] LW  = 32'h8D090100;
  localparam logic [31:0] SW  = 32'hAD0A0200;
  localparam logic [31:0] BEQ = 32'h11090004;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] core_pc, core_memaddr, mem_addr;
  logic [DW-1:0] core_instr, core_writedata, core_readdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          core_memread, core_memwrite, core_stall;
  logic          mem_req, mem_we, bus_err;
  logic          mem_ack = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  acc_t        exp_q[$];
  logic [31:0] exp_rd;
  logic [31:0] iword, dword;
  int          lf_wait, ld_wait, wcnt = 0, phase = 0;
  bit          spur, force_both;

  always #5 clk = ~clk;

  mips_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .core_pc(core_pc), .core_instr(core_instr),
    .core_memread(core_memread), .core_memwrite(core_memwrite),
    .core_memaddr(core_memaddr), .core_writedata(core_writedata),
    .core_readdata(core_readdata), .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  // Core-side decode of the latched instruction.
  always_comb begin
    core_memread  = (core_instr[31:26] == 6'h23) || force_both;
    core_memwrite = (core_instr[31:26] == 6'h2b) || force_both;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the expected access stream, then memory response.
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0; mem_rdata = '0; wcnt = 0; phase = 0;
    end else begin
      if (mem_req) begin
        chk("req_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          chk("req_addr", mem_addr, exp_q[0].addr);
          chk("req_we", mem_we, exp_q[0].we);
          if (exp_q[0].we) chk("req_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (!core_stall) begin
        chk("exec_req", mem_req, 0);
        chk("exec_addr", mem_addr, 0);
        chk("exec_we", mem_we, 0);
        chk("exec_wdata", mem_wdata, 0);
        chk("exec_err", bus_err, 0);
      end
      if (mem_req && wcnt >= ((phase == 0) ? lf_wait : ld_wait)) begin
        mem_ack   = 1'b1;
        mem_rdata = (phase == 0) ? iword : dword;
        wcnt      = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        phase = (phase == 0 && exp_q.size() > 0) ? 1 : 0;
      end else if (mem_req) begin
        mem_ack = 1'b0; mem_rdata = '0; wcnt++;
      end else begin
        mem_ack = spur; mem_rdata = spur ? 32'hFFFF_FFFF : '0; wcnt = 0;
      end
    end
  end

  task automatic setup(input logic [31:0] pc, instr, maddr, wdata, dval,
                       input int lw, dw, input bit both);
    logic [5:0] op;
    op = instr[31:26];
    core_pc = pc; iword = instr; core_memaddr = maddr; core_writedata = wdata;
    dword = dval; lf_wait = lw; ld_wait = dw; force_both = both;
    exp_q.push_back('{pc, 1'b0, 32'h0});
    if (both || op == 6'h2b)  exp_q.push_back('{maddr, 1'b1, wdata});
    else if (op == 6'h23) begin
      exp_q.push_back('{maddr, 1'b0, wdata});
      exp_rd = dval;
    end
  endtask

  // Waits for the single EXEC cycle and checks cost and latched state there.
  task automatic run_one(input string nm, input int exp_cyc, input logic [31:0] exp_instr);
    int n = 0;
    bit got = 0;
    while (n < 80 && !got) begin
      @(negedge clk);
      n++;
      if (!core_stall) got = 1;
    end
    chk({nm, "_reach_exec"}, got, 1);
    if (got) begin
      chk({nm, "_cycles"}, n, exp_cyc);
      chk({nm, "_instr"}, core_instr, exp_instr);
      chk({nm, "_readdata"}, core_readdata, exp_rd);
      chk({nm, "_all_accesses"}, exp_q.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1; core_pc = '0; core_memaddr = '0; core_writedata = '0;
    spur = 0; force_both = 0; exp_rd = '0; iword = '0; dword = '0;
    lf_wait = 0; ld_wait = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_stall", core_stall, 1);
    chk("rst_instr", core_instr, 0);
    chk("rst_readdata", core_readdata, 0);
    chk("rst_err", bus_err, 0);

    // IDLE, FETCH, DECIDE, EXEC: EXEC lands 3 cycles after reset release.
    setup(32'h0, ADD, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    run_one("add_zw", 3, ADD);
    setup(32'h4, LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, 0);
    run_one("lw_wait3", 7, LW);
    chk("lw_literal", core_readdata, 32'hDEADBEEF);
    setup(32'h8, SW, 32'h200, 32'h12345678, 32'h55555555, 1, 0, 0);
    run_one("sw", 5, SW);
    setup(32'hC, BEQ, 32'h0, 32'h0, 32'h0, 2, 0, 0);
    run_one("beq_wait2", 5, BEQ);
    setup(32'h10, LW, 32'h300, 32'hA5A5A5A5, 32'h77777777, 0, 1, 1);
    run_one("rd_wr_both", 5, LW);
    // Acks on the TIMEOUT-th req cycle of both accesses must not trip the watchdog.
    setup(32'h14, LW, 32'h104, 32'h0, 32'h0BADF00D, TO - 1, TO - 1, 0);
    run_one("ack_at_limit", 2 * TO + 2, LW);
    chk("ack_at_limit_err", bus_err, 0);

    spur = 1;
    setup(32'h18, ADD, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    run_one("spur_add", 3, ADD);
    setup(32'h1C, LW, 32'h108, 32'h0, 32'h13579BDF, 0, 0, 0);
    run_one("spur_lw", 4, LW);
    spur = 0;

    // Abandon a load two cycles into its data phase.
    setup(32'h20, LW, 32'h10C, 32'h0, 32'h2468ACE0, 0, 10, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", mem_req, 0);
    chk("midrst_instr", core_instr, 0);
    chk("midrst_readdata", core_readdata, 0);
    chk("midrst_stall", core_stall, 1);
    exp_q.delete(); exp_rd = '0;
    setup(32'h40, ADD, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    run_one("refetch", 3, ADD);

    // Memory never acks: ERR on the edge ending the TO-th fetch cycle.
    setup(32'h50, ADD, 32'h0, 32'h0, 32'h0, 1000, 0, 0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("wd_pre_err", bus_err, 0);
      chk("wd_pre_req", mem_req, 1);
    end
    @(negedge clk);
    chk("wd_err", bus_err, 1);
    chk("wd_req_drop", mem_req, 0);
    chk("wd_stall", core_stall, 1);
    repeat (3) @(negedge clk);
    chk("wd_err_sticky", bus_err, 1);
    chk("wd_req_stays_low", mem_req, 0);
    chk("wd_stall_stays", core_stall, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("wd_rst_clears", bus_err, 0);
    exp_q.delete(); exp_rd = '0;
    setup(32'h60, ADD, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    run_one("recover", 3, ADD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
